// File: rtl/gnrl_pipe_fifo_pkg.sv
// Shared types and width helpers for the pipeline FIFO slice.
package gnrl_pipe_fifo_pkg;

  // Per-cycle handshake outcome, encoded as {push, pop}.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // Pointer width: a single-entry FIFO still needs one pointer bit.
  function automatic int ptr_width(input int dp);
    return (dp > 1) ? $clog2(dp) : 1;
  endfunction

  // Occupancy width: must be able to represent 0..dp inclusive.
  function automatic int count_width(input int dp);
    return $clog2(dp + 1);
  endfunction

endpackage

// File: rtl/gnrl_dffl.sv
// Load-enable storage register without reset, used for FIFO data entries.
module gnrl_dffl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] qout_d;
  logic [DW-1:0] qout_q;

  // Capture new data only when the load enable is high, otherwise hold.
  always_comb begin
    qout_d = qout_q;
    if (lden) qout_d = dnxt;
  end

  // Data storage flop; deliberately has no reset.
  always_ff @(posedge clk) begin
    qout_q <= qout_d;
  end

  assign qout = qout_q;

endmodule

// File: rtl/gnrl_fifo_ptr.sv
// Wrapping pointer counter for FIFO read/write positions.
module gnrl_fifo_ptr
  import gnrl_pipe_fifo_pkg::*;
#(
  parameter int DP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     inc,
  output logic [ptr_width(DP)-1:0] ptr
);

  localparam int            PW   = ptr_width(DP);
  localparam logic [PW-1:0] LAST = PW'(DP - 1);

  logic [PW-1:0] ptr_d;
  logic [PW-1:0] ptr_q;

  // Clear wins over increment; wrap explicitly so non-power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/gnrl_pipe_fifo.sv
// Synchronous valid/ready FIFO decoupling two pipeline stages in one clock domain.
module gnrl_pipe_fifo
  import gnrl_pipe_fifo_pkg::*;
#(
  parameter int DW = 32,
  parameter int DP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       i_vld,
  output logic                       i_rdy,
  input  logic [DW-1:0]              i_dat,
  output logic                       o_vld,
  input  logic                       o_rdy,
  output logic [DW-1:0]              o_dat,
  output logic [count_width(DP)-1:0] count
);

  localparam int            PW   = ptr_width(DP);
  localparam int            CW   = count_width(DP);
  localparam logic [CW-1:0] FULL = CW'(DP);

  logic          push;
  logic          pop;
  logic          wr_en;
  fifo_op_e      op;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;
  logic [DW-1:0] mem [DP];

  // Ready/valid come only from registered occupancy: no pass-through or bypass.
  assign i_rdy = (count_q != FULL);
  assign o_vld = (count_q != '0);
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;
  assign wr_en = push & ~flush;
  assign op    = fifo_op_e'({push, pop});

  gnrl_fifo_ptr #(.DP(DP)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rptr)
  );

  gnrl_fifo_ptr #(.DP(DP)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push),
    .ptr   (wptr)
  );

  for (genvar k = 0; k < DP; k++) begin : g_mem
    gnrl_dffl #(.DW(DW)) u_entry (
      .clk  (clk),
      .lden (wr_en & (wptr == PW'(k))),
      .dnxt (i_dat),
      .qout (mem[k])
    );
  end

  // Head-of-queue read mux; explicit compare keeps non-power-of-two depths in range.
  always_comb begin
    o_dat = mem[0];
    for (int k = 0; k < DP; k++) begin
      if (rptr == PW'(k)) o_dat = mem[k];
    end
  end

  // Occupancy update: flush empties, simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case (op)
        FIFO_PUSH: count_d = count_q + CW'(1);
        FIFO_POP:  count_d = count_q - CW'(1);
        default:   count_d = count_q;
      endcase
    end
  end

  // Occupancy register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

  a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n)
                                 !$isunknown({i_vld, o_rdy, flush}));

endmodule

// File: tb/tb_gnrl_pipe_fifo.sv
// Bench for gnrl_pipe_fifo: DP=4, DP=1 and DP=3 instances against a queue model.
module tb_gnrl_pipe_fifo;

  typedef logic [31:0] word_t;
  typedef word_t wq_t[$];

  logic        clk = 1'b0;
  logic [2:0]  rstn;
  logic [2:0]  flsh;
  logic [2:0]  ivld;
  logic [2:0]  ordy;
  logic [2:0]  irdy;
  logic [2:0]  ovld;
  word_t       idat [3];
  word_t       odat [3];
  logic [2:0]  cnt4;
  logic        cnt1;
  logic [1:0]  cnt3;

  wq_t mq0;
  wq_t mq1;
  wq_t mq2;
  int  dps [3] = '{4, 1, 3};
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  gnrl_pipe_fifo #(.DW(32), .DP(4)) dut4 (
    .clk(clk), .rst_n(rstn[0]), .flush(flsh[0]),
    .i_vld(ivld[0]), .i_rdy(irdy[0]), .i_dat(idat[0]),
    .o_vld(ovld[0]), .o_rdy(ordy[0]), .o_dat(odat[0]), .count(cnt4)
  );

  gnrl_pipe_fifo #(.DW(32), .DP(1)) dut1 (
    .clk(clk), .rst_n(rstn[1]), .flush(flsh[1]),
    .i_vld(ivld[1]), .i_rdy(irdy[1]), .i_dat(idat[1]),
    .o_vld(ovld[1]), .o_rdy(ordy[1]), .o_dat(odat[1]), .count(cnt1)
  );

  gnrl_pipe_fifo #(.DW(32), .DP(3)) dut3 (
    .clk(clk), .rst_n(rstn[2]), .flush(flsh[2]),
    .i_vld(ivld[2]), .i_rdy(irdy[2]), .i_dat(idat[2]),
    .o_vld(ovld[2]), .o_rdy(ordy[2]), .o_dat(odat[2]), .count(cnt3)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: an ordered queue of words, bounded by the depth.
  function automatic wq_t modelNext(input wq_t q, input int dp, input logic rn, input logic fl,
                                    input logic vld, input logic rdy, input word_t dat);
    wq_t n;
    bit  do_pop;
    bit  do_push;
    n = q;
    if (!rn || fl) begin
      n.delete();
      return n;
    end
    do_pop  = (q.size() > 0) && rdy;
    do_push = (q.size() < dp) && vld;
    if (do_pop)  void'(n.pop_front());
    if (do_push) n.push_back(dat);
    return n;
  endfunction

  // Compare one instance against its model queue.
  task automatic checkInst(input int i, input wq_t q, input logic [63:0] cnt);
    string p;
    p = $sformatf("dp%0d_", dps[i]);
    checkOutput({p, "o_vld"}, {63'd0, ovld[i]}, {63'd0, q.size() != 0});
    checkOutput({p, "i_rdy"}, {63'd0, irdy[i]}, {63'd0, q.size() != dps[i]});
    checkOutput({p, "count"}, cnt, 64'(q.size()));
    if (q.size() > 0) checkOutput({p, "o_dat"}, {32'd0, odat[i]}, {32'd0, q[0]});
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    mq0 = modelNext(mq0, 4, rstn[0], flsh[0], ivld[0], ordy[0], idat[0]);
    mq1 = modelNext(mq1, 1, rstn[1], flsh[1], ivld[1], ordy[1], idat[1]);
    mq2 = modelNext(mq2, 3, rstn[2], flsh[2], ivld[2], ordy[2], idat[2]);
    @(negedge clk);
    checkInst(0, mq0, {61'd0, cnt4});
    checkInst(1, mq1, {63'd0, cnt1});
    checkInst(2, mq2, {62'd0, cnt3});
  endtask

  initial begin
    int  sz [3];
    bit  acc [3];

    rstn = 3'b000;
    flsh = 3'b000;
    ivld = 3'b000;
    ordy = 3'b000;
    for (int i = 0; i < 3; i++) idat[i] = '0;

    // Reset for two cycles, then idle with the consumer ready.
    applyStimulus();
    applyStimulus();
    rstn = 3'b111;
    ordy[0] = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("idle_count", {61'd0, cnt4}, 64'd0);

    // Fill to full, then offer a fifth word that must be refused.
    ordy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ivld[0] = 1'b1;
      idat[0] = 32'hA0 + 32'(k);
      applyStimulus();
    end
    checkOutput("fill_count", {61'd0, cnt4}, 64'd4);
    checkOutput("fill_irdy", {63'd0, irdy[0]}, 64'd0);
    idat[0] = 32'hA4;
    applyStimulus();
    checkOutput("full_hold", {61'd0, cnt4}, 64'd4);
    ivld[0] = 1'b0;
    ordy[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain_dat", {32'd0, odat[0]}, 64'hA0 + 64'(k));
      applyStimulus();
    end
    checkOutput("drain_empty", {63'd0, ovld[0]}, 64'd0);

    // Streaming at occupancy one across several pointer wraps.
    ordy[0] = 1'b0;
    ivld[0] = 1'b1;
    idat[0] = 32'hFF;
    applyStimulus();
    ordy[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      idat[0] = 32'h100 + 32'(k);
      applyStimulus();
      checkOutput("stream_count", {61'd0, cnt4}, 64'd1);
      checkOutput("stream_dat", {32'd0, odat[0]}, 64'h100 + 64'(k));
    end
    ivld[0] = 1'b0;
    applyStimulus();

    // Full with a simultaneous pop: the push waits one cycle.
    ordy[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ivld[0] = 1'b1;
      idat[0] = 32'hB0 + 32'(k);
      applyStimulus();
    end
    idat[0] = 32'hB5;
    ordy[0] = 1'b1;
    applyStimulus();
    checkOutput("fullpop_count", {61'd0, cnt4}, 64'd3);
    ordy[0] = 1'b0;
    applyStimulus();
    checkOutput("fullpop_retry", {61'd0, cnt4}, 64'd4);
    ivld[0] = 1'b0;

    // Flush with a concurrent push at occupancy three.
    ordy[0] = 1'b1;
    applyStimulus();
    ordy[0] = 1'b0;
    flsh[0] = 1'b1;
    ivld[0] = 1'b1;
    idat[0] = 32'hDEAD;
    applyStimulus();
    checkOutput("flush_count", {61'd0, cnt4}, 64'd0);
    checkOutput("flush_ovld", {63'd0, ovld[0]}, 64'd0);
    flsh[0] = 1'b0;

    // Reset mid-operation with a concurrent push.
    for (int k = 0; k < 3; k++) begin
      idat[0] = 32'hD0 + 32'(k);
      applyStimulus();
    end
    rstn[0] = 1'b0;
    idat[0] = 32'hBEEF;
    applyStimulus();
    checkOutput("rst_count", {61'd0, cnt4}, 64'd0);
    checkOutput("rst_ovld", {63'd0, ovld[0]}, 64'd0);
    rstn[0] = 1'b1;
    idat[0] = 32'hC0;
    applyStimulus();
    ivld[0] = 1'b0;
    checkOutput("post_rst_dat", {32'd0, odat[0]}, 64'hC0);
    checkOutput("post_rst_count", {61'd0, cnt4}, 64'd1);
    ordy[0] = 1'b1;
    applyStimulus();

    // Randomized traffic on all three depths; producers hold until accepted.
    for (int i = 0; i < 3; i++) acc[i] = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!ivld[i] || acc[i]) begin
          ivld[i] = ($urandom_range(0, 99) < 60);
          idat[i] = $urandom;
        end
        ordy[i] = ($urandom_range(0, 99) < 50);
        flsh[i] = ($urandom_range(0, 199) == 0);
      end
      sz[0] = mq0.size();
      sz[1] = mq1.size();
      sz[2] = mq2.size();
      for (int i = 0; i < 3; i++) acc[i] = ivld[i] && !flsh[i] && (sz[i] < dps[i]);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
